// File: rtl/pc_seq_pkg.sv
// Shared types and default constants for the program-counter sequencer.
// The return-address stack is built only when PC_SEQ_RAS_EN is defined.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_J,
    SEL_JR
  } next_sel_e;

  localparam int          DEF_DATA_W      = 16;
  localparam int          DEF_INSTR_BYTES = 2;
  localparam logic [15:0] DEF_RESET_VEC   = 16'h0000;
  localparam int          DEF_RAS_DEPTH   = 4;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// and a simultaneous push/pop replaces the top entry in place.
module pc_ras #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          push_data,
  output logic [DATA_W-1:0]          top,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  sp;
  logic [PTR_W-1:0]  top_idx;
  logic              do_pop;

  // sp names the next free slot; the power-of-two depth makes wraparound free
  assign top_idx = sp - 1'b1;
  assign do_pop  = pop & (count != '0);
  assign top     = mem[top_idx];
  assign empty   = (count == '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[do_pop ? top_idx : sp] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp    <= '0;
      count <= '0;
    end else if (push && !do_pop) begin
      sp    <= sp + 1'b1;
      count <= (count == CNT_W'(DEPTH)) ? count : count + 1'b1;
    end else if (do_pop && !push) begin
      sp    <= sp - 1'b1;
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC selection with jr/jump/branch priority, target alignment and redirect flush.
// Define PC_SEQ_RAS_EN to add the return-address stack used by ctl_call/ctl_jr.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                DATA_W      = DEF_DATA_W,
  parameter int                INSTR_BYTES = DEF_INSTR_BYTES,
  parameter logic [DATA_W-1:0] RESET_VEC   = DATA_W'(DEF_RESET_VEC),
  parameter int                RAS_DEPTH   = DEF_RAS_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              instr_valid,
  input  logic              ctl_branch,
  input  logic              ctl_jump,
  input  logic              ctl_jr,
  input  logic              ctl_call,
  input  logic              alu_zero,
  input  logic [DATA_W-1:0] br_target,
  input  logic [DATA_W-1:0] j_target,
  input  logic [DATA_W-1:0] jr_target,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] pc_plus,
  output logic              flush,
  output logic              misalign,
  output logic              ras_miss,
  output logic              ras_empty
);

  localparam logic [DATA_W-1:0] ALIGN_MASK = DATA_W'(INSTR_BYTES - 1);

  logic [DATA_W-1:0] pc_q;
  logic              flush_q;
  logic              misalign_q;
  logic              ras_miss_q;
  logic              accepted;
  logic [DATA_W-1:0] jr_src;
  logic              jr_miss;
  next_sel_e         sel;
  logic [DATA_W-1:0] raw_target;
  logic [DATA_W-1:0] next_pc;
  logic              target_misaligned;

  assign accepted = instr_valid & ~stall;
  assign pc_plus  = pc_q + DATA_W'(INSTR_BYTES);
  assign pc_out   = pc_q;
  assign flush    = flush_q;
  assign misalign = misalign_q;
  assign ras_miss = ras_miss_q;

`ifdef PC_SEQ_RAS_EN
  logic [DATA_W-1:0]          ras_top;
  logic [$clog2(RAS_DEPTH):0] ras_count;
  logic                       ras_push;
  logic                       ras_pop;

  assign ras_push = accepted & ctl_call;
  assign ras_pop  = accepted & ctl_jr & (ras_count != '0);
  assign jr_src   = ras_pop ? ras_top : jr_target;
  assign jr_miss  = accepted & ctl_jr & (ras_count == '0);

  pc_ras #(
    .DATA_W (DATA_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus),
    .top       (ras_top),
    .count     (ras_count),
    .empty     (ras_empty)
  );
`else
  logic unused_call;

  assign unused_call = ctl_call;
  assign jr_src      = jr_target;
  assign jr_miss     = 1'b0;
  assign ras_empty   = 1'b1;
`endif

  always_comb begin
    sel = SEL_SEQ;
    if (accepted) begin
      if (ctl_jr)                      sel = SEL_JR;
      else if (ctl_jump)               sel = SEL_J;
      else if (ctl_branch && alu_zero) sel = SEL_BR;
    end
  end

  always_comb begin
    raw_target = pc_plus;
    case (sel)
      SEL_JR:  raw_target = jr_src;
      SEL_J:   raw_target = j_target;
      SEL_BR:  raw_target = br_target;
      default: raw_target = pc_plus;
    endcase
  end

  // A taken branch landing on pc_plus still counts as a redirect for flush
  assign next_pc           = raw_target & ~ALIGN_MASK;
  assign target_misaligned = (sel != SEL_SEQ) && ((raw_target & ALIGN_MASK) != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_VEC;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
      ras_miss_q <= 1'b0;
    end else if (!stall) begin
      pc_q       <= next_pc;
      flush_q    <= (sel != SEL_SEQ);
      misalign_q <= target_misaligned;
      ras_miss_q <= jr_miss;
    end else begin
      misalign_q <= 1'b0;
      ras_miss_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; RAS scenarios run when PC_SEQ_RAS_EN is defined.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, instr_valid;
  logic        ctl_branch, ctl_jump, ctl_jr, ctl_call, alu_zero;
  logic [15:0] br_target, j_target, jr_target;
  logic [15:0] pc_out, pc_plus;
  logic        flush, misalign, ras_miss, ras_empty;

  int checks   = 0;
  int failures = 0;

  pc_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .instr_valid (instr_valid),
    .ctl_branch  (ctl_branch),
    .ctl_jump    (ctl_jump),
    .ctl_jr      (ctl_jr),
    .ctl_call    (ctl_call),
    .alu_zero    (alu_zero),
    .br_target   (br_target),
    .j_target    (j_target),
    .jr_target   (jr_target),
    .pc_out      (pc_out),
    .pc_plus     (pc_plus),
    .flush       (flush),
    .misalign    (misalign),
    .ras_miss    (ras_miss),
    .ras_empty   (ras_empty)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic v, input logic s, input logic jr, input logic jmp,
                                input logic br, input logic z, input logic call,
                                input logic [15:0] jt, input logic [15:0] jrt, input logic [15:0] bt);
    instr_valid = v;
    stall       = s;
    ctl_jr      = jr;
    ctl_jump    = jmp;
    ctl_branch  = br;
    alu_zero    = z;
    ctl_call    = call;
    j_target    = jt;
    jr_target   = jrt;
    br_target   = bt;
  endtask

  task automatic idle();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    #2;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    #2;
    checks++; if (pc_out !== 16'h0000) begin failures++; $display("[TB] FAIL reset_pc actual=%h expected=%h", pc_out, 16'h0000); end
    checks++; if (pc_plus !== 16'h0002) begin failures++; $display("[TB] FAIL reset_pc_plus actual=%h expected=%h", pc_plus, 16'h0002); end
    checks++; if (flush !== 1'b0) begin failures++; $display("[TB] FAIL reset_flush actual=%b expected=0", flush); end
    checks++; if (ras_empty !== 1'b1) begin failures++; $display("[TB] FAIL reset_ras_empty actual=%b expected=1", ras_empty); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++; if (pc_out !== 16'h0002) begin failures++; $display("[TB] FAIL reset_first_edge actual=%h expected=%h", pc_out, 16'h0002); end
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0040, 16'h0, 16'h0);
    step();
    checks++; if (pc_out !== 16'h0040) begin failures++; $display("[TB] FAIL jump_to_40 actual=%h expected=%h", pc_out, 16'h0040); end
    checks++; if (flush !== 1'b1) begin failures++; $display("[TB] FAIL jump_flush actual=%b expected=1", flush); end
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0100, 16'h0, 16'h0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (pc_out !== 16'h0000) begin failures++; $display("[TB] FAIL async_reset_pc actual=%h expected=%h", pc_out, 16'h0000); end
    checks++; if (flush !== 1'b0) begin failures++; $display("[TB] FAIL async_reset_flush actual=%b expected=0", flush); end
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++; if (pc_out !== 16'h0002) begin failures++; $display("[TB] FAIL redirect_discarded actual=%h expected=%h", pc_out, 16'h0002); end
    checks++; if (flush !== 1'b0) begin failures++; $display("[TB] FAIL post_reset_flush actual=%b expected=0", flush); end
  endtask

  task automatic test_priority();
    logic exp_miss;
`ifdef PC_SEQ_RAS_EN
    exp_miss = 1'b1;
`else
    exp_miss = 1'b0;
`endif
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0200, 16'h0100, 16'h0300);
    step();
    checks++; if (pc_out !== 16'h0100) begin failures++; $display("[TB] FAIL prio_jr actual=%h expected=%h", pc_out, 16'h0100); end
    checks++; if (flush !== 1'b1) begin failures++; $display("[TB] FAIL prio_flush actual=%b expected=1", flush); end
    checks++; if (ras_miss !== exp_miss) begin failures++; $display("[TB] FAIL prio_ras_miss actual=%b expected=%b", ras_miss, exp_miss); end
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    step();
    checks++; if (pc_out !== 16'h0102) begin failures++; $display("[TB] FAIL seq_after_jr actual=%h expected=%h", pc_out, 16'h0102); end
    checks++; if (flush !== 1'b0) begin failures++; $display("[TB] FAIL flush_one_cycle actual=%b expected=0", flush); end
    checks++; if (ras_miss !== 1'b0) begin failures++; $display("[TB] FAIL ras_miss_pulse actual=%b expected=0", ras_miss); end
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0200, 16'h0, 16'h0300);
    step();
    checks++; if (pc_out !== 16'h0200) begin failures++; $display("[TB] FAIL prio_jump_over_br actual=%h expected=%h", pc_out, 16'h0200); end
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0300);
    step();
    checks++; if (pc_out !== 16'h0202) begin failures++; $display("[TB] FAIL br_not_taken actual=%h expected=%h", pc_out, 16'h0202); end
    checks++; if (flush !== 1'b0) begin failures++; $display("[TB] FAIL br_not_taken_flush actual=%b expected=0", flush); end
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0204);
    step();
    checks++; if (pc_out !== 16'h0204) begin failures++; $display("[TB] FAIL br_to_pc_plus actual=%h expected=%h", pc_out, 16'h0204); end
    checks++; if (flush !== 1'b1) begin failures++; $display("[TB] FAIL br_to_pc_plus_flush actual=%b expected=1", flush); end
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0500, 16'h0, 16'h0);
    step();
    checks++; if (pc_out !== 16'h0206) begin failures++; $display("[TB] FAIL invalid_ignored actual=%h expected=%h", pc_out, 16'h0206); end
    checks++; if (flush !== 1'b0) begin failures++; $display("[TB] FAIL invalid_flush actual=%b expected=0", flush); end
  endtask

  task automatic test_stall();
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0080, 16'h0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (pc_out !== 16'h0206) begin failures++; $display("[TB] FAIL stall_hold_pc cycle=%0d actual=%h expected=%h", i, pc_out, 16'h0206); end
      checks++; if (flush !== 1'b0) begin failures++; $display("[TB] FAIL stall_hold_flush cycle=%0d actual=%b expected=0", i, flush); end
    end
    stall = 1'b0;
    step();
    checks++; if (pc_out !== 16'h0080) begin failures++; $display("[TB] FAIL stall_release actual=%h expected=%h", pc_out, 16'h0080); end
    checks++; if (flush !== 1'b1) begin failures++; $display("[TB] FAIL stall_release_flush actual=%b expected=1", flush); end
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0090, 16'h0, 16'h0);
    step();
    checks++; if (pc_out !== 16'h0080) begin failures++; $display("[TB] FAIL stall_keep_pc actual=%h expected=%h", pc_out, 16'h0080); end
    checks++; if (flush !== 1'b1) begin failures++; $display("[TB] FAIL stall_keep_flush actual=%b expected=1", flush); end
    idle();
    step();
    checks++; if (pc_out !== 16'h0082) begin failures++; $display("[TB] FAIL stall_then_seq actual=%h expected=%h", pc_out, 16'h0082); end
  endtask

  task automatic test_misalign_wrap();
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0081, 16'h0, 16'h0);
    step();
    checks++; if (pc_out !== 16'h0080) begin failures++; $display("[TB] FAIL misalign_pc actual=%h expected=%h", pc_out, 16'h0080); end
    checks++; if (misalign !== 1'b1) begin failures++; $display("[TB] FAIL misalign_pulse actual=%b expected=1", misalign); end
    idle();
    step();
    checks++; if (misalign !== 1'b0) begin failures++; $display("[TB] FAIL misalign_clear actual=%b expected=0", misalign); end
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0123);
    step();
    checks++; if (pc_out !== 16'h0122) begin failures++; $display("[TB] FAIL br_misalign_pc actual=%h expected=%h", pc_out, 16'h0122); end
    checks++; if (misalign !== 1'b1) begin failures++; $display("[TB] FAIL br_misalign_pulse actual=%b expected=1", misalign); end
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFE, 16'h0, 16'h0);
    step();
    checks++; if (misalign !== 1'b0) begin failures++; $display("[TB] FAIL aligned_no_misalign actual=%b expected=0", misalign); end
    checks++; if (pc_plus !== 16'h0000) begin failures++; $display("[TB] FAIL wrap_pc_plus actual=%h expected=%h", pc_plus, 16'h0000); end
    idle();
    step();
    checks++; if (pc_out !== 16'h0000) begin failures++; $display("[TB] FAIL wrap_pc actual=%h expected=%h", pc_out, 16'h0000); end
  endtask

`ifdef PC_SEQ_RAS_EN
  task automatic test_ras();
    logic [15:0] jumps [5];
    logic [15:0] rets  [4];
    jumps = '{16'h0020, 16'h0030, 16'h0040, 16'h0050, 16'h0100};
    rets  = '{16'h0052, 16'h0042, 16'h0032, 16'h0022};
    do_reset();
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0, 16'h0);
    step();
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, jumps[i], 16'h0, 16'h0);
      step();
    end
    checks++; if (pc_out !== 16'h0100) begin failures++; $display("[TB] FAIL ras_calls_pc actual=%h expected=%h", pc_out, 16'h0100); end
    checks++; if (ras_empty !== 1'b0) begin failures++; $display("[TB] FAIL ras_not_empty actual=%b expected=0", ras_empty); end
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0400, 16'h0);
      step();
      checks++; if (pc_out !== rets[i]) begin failures++; $display("[TB] FAIL ras_pop%0d actual=%h expected=%h", i, pc_out, rets[i]); end
      checks++; if (ras_miss !== 1'b0) begin failures++; $display("[TB] FAIL ras_pop%0d_miss actual=%b expected=0", i, ras_miss); end
    end
    checks++; if (ras_empty !== 1'b1) begin failures++; $display("[TB] FAIL ras_drained actual=%b expected=1", ras_empty); end
    step();
    checks++; if (pc_out !== 16'h0400) begin failures++; $display("[TB] FAIL ras_miss_target actual=%h expected=%h", pc_out, 16'h0400); end
    checks++; if (ras_miss !== 1'b1) begin failures++; $display("[TB] FAIL ras_miss_pulse actual=%b expected=1", ras_miss); end
    idle();
    step();
    checks++; if (ras_miss !== 1'b0) begin failures++; $display("[TB] FAIL ras_miss_clear actual=%b expected=0", ras_miss); end
  endtask

  task automatic test_jalr();
    do_reset();
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0030, 16'h0, 16'h0);
    step();
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0060, 16'h0, 16'h0);
    step();
    checks++; if (pc_out !== 16'h0060) begin failures++; $display("[TB] FAIL jalr_setup_pc actual=%h expected=%h", pc_out, 16'h0060); end
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0300, 16'h0);
    step();
    checks++; if (pc_out !== 16'h0032) begin failures++; $display("[TB] FAIL jalr_target actual=%h expected=%h", pc_out, 16'h0032); end
    checks++; if (ras_empty !== 1'b0) begin failures++; $display("[TB] FAIL jalr_count_kept actual=%b expected=0", ras_empty); end
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0300, 16'h0);
    step();
    checks++; if (pc_out !== 16'h0062) begin failures++; $display("[TB] FAIL jalr_new_top actual=%h expected=%h", pc_out, 16'h0062); end
    checks++; if (ras_empty !== 1'b1) begin failures++; $display("[TB] FAIL jalr_single_entry actual=%b expected=1", ras_empty); end
    step();
    checks++; if (pc_out !== 16'h0300) begin failures++; $display("[TB] FAIL jalr_then_miss actual=%h expected=%h", pc_out, 16'h0300); end
    checks++; if (ras_miss !== 1'b1) begin failures++; $display("[TB] FAIL jalr_miss_pulse actual=%b expected=1", ras_miss); end
    idle();
  endtask
`else
  task automatic test_no_ras();
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0040, 16'h0, 16'h0);
    step();
    checks++; if (ras_empty !== 1'b1) begin failures++; $display("[TB] FAIL no_ras_empty actual=%b expected=1", ras_empty); end
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0120, 16'h0);
    step();
    checks++; if (pc_out !== 16'h0120) begin failures++; $display("[TB] FAIL no_ras_jr actual=%h expected=%h", pc_out, 16'h0120); end
    checks++; if (ras_miss !== 1'b0) begin failures++; $display("[TB] FAIL no_ras_miss actual=%b expected=0", ras_miss); end
    idle();
  endtask
`endif

  initial begin
    $display("[TB] pc_sequencer directed tests starting");
    test_reset();
    test_priority();
    test_stall();
    test_misalign_wrap();
`ifdef PC_SEQ_RAS_EN
    test_ras();
    test_jalr();
`else
    test_no_ras();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, 16, PC and target width in bits.
REQ-002 SHALL have parameter INSTR_BYTES, 2, sequential increment; power of two, at least 2.
REQ-003 SHALL have parameter RESET_VEC, 16'h0000, PC value loaded on reset.
REQ-004 SHALL have parameter RAS_DEPTH, 4, return-address stack entries; power of two, at least 2.
REQ-005 SHALL have ports: clk in 1 clock; rst_n in 1 reset, asynchronous, active-low.
REQ-006 SHALL have ports: stall in 1, hold PC; instr_valid in 1, decode slot holds a real instruction.
REQ-007 SHALL have ports: ctl_branch, ctl_jump, ctl_jr, ctl_call in 1 each; alu_zero in 1.
REQ-008 SHALL have ports: br_target, j_target, jr_target in DATA_W each.
REQ-009 SHALL have ports: pc_out out DATA_W current PC; pc_plus out DATA_W, pc_out+INSTR_BYTES.
REQ-010 SHALL have ports: flush out 1, kill fetched slot; misalign out 1; ras_miss out 1; ras_empty out 1.

Function
REQ-011 SHALL hold pc_q in a register; pc_out = pc_q; pc_plus is combinational, wrapping modulo 2^DATA_W.
REQ-012 SHALL accept control inputs only when instr_valid=1 and stall=0 ("accepted cycle"); otherwise all ctl_* are ignored.
REQ-013 SHALL select the next PC by priority ctl_jr > ctl_jump > (ctl_branch & alu_zero) > pc_plus.
REQ-014 SHALL load next PC on the rising clk edge of an accepted cycle; with instr_valid=0 and stall=0, pc_plus is loaded.
REQ-015 SHALL keep pc_q, RAS and flush unchanged while stall=1; upstream holds inputs until stall drops.
REQ-016 SHALL force the log2(INSTR_BYTES) LSBs of any selected target to 0, and pulse misalign, registered, for 1 cycle when they were non-zero.
REQ-017 SHALL register flush=1 for exactly one cycle after an accepted cycle that took a non-sequential target, including a branch to pc_plus.
REQ-018 SHALL drive ras_miss and misalign as registered single-cycle pulses.

Reset
REQ-019 SHALL on rst_n=0, immediately and asynchronously, set pc_q=RESET_VEC, flush=0, misalign=0, ras_miss=0, RAS count=0, ras_empty=1.
REQ-020 SHALL discard an in-flight redirect when reset asserts mid-operation; the first post-reset edge loads RESET_VEC+INSTR_BYTES.

Configuration
REQ-021 SHALL compile the return-address stack only when PC_SEQ_RAS_EN is defined.
REQ-022 With PC_SEQ_RAS_EN, an accepted ctl_call SHALL push pc_plus. An accepted ctl_jr SHALL pop and use the popped value as target when non-empty; when empty it SHALL use jr_target and pulse ras_miss.
REQ-023 With PC_SEQ_RAS_EN, a push when full SHALL overwrite the oldest entry, with count saturating at RAS_DEPTH. Simultaneous ctl_jr and ctl_call SHALL pop first and then push, leaving count unchanged.
REQ-024 Without PC_SEQ_RAS_EN, ctl_jr SHALL always use jr_target, ctl_call only selects nothing extra, ras_empty=1 and ras_miss=0 constantly.

Structure
REQ-025 SHALL take a shared package pc_seq_pkg holding the next-PC select enum {SEL_SEQ, SEL_BR, SEL_J, SEL_JR} and the default parameter constants.
REQ-026 SHALL implement the stack as sub-module pc_ras: circular buffer with push, pop, top, count and empty; instantiated only under PC_SEQ_RAS_EN.

Verification
REQ-027 Reset: rst_n low mid-run, pc_q=16'h0040 -> pc_out=16'h0000 with no clock edge; the first edge after release gives pc_out=16'h0002.
REQ-028 Priority: ctl_jr=ctl_jump=ctl_branch=alu_zero=1, jr_target=16'h0100, j_target=16'h0200 -> pc_out=16'h0100 next cycle, flush=1 for 1 cycle.
REQ-029 Stall: stall=1 for 3 cycles with ctl_jump=1, j_target=16'h0080 -> pc_out is constant; on stall=0 the next edge gives 16'h0080.
REQ-030 Misalign and wrap: j_target=16'h0081 -> pc_out=16'h0080 and a misalign pulse; pc_q=16'hFFFE sequential -> pc_out=16'h0000.
REQ-031 RAS (macro on): 5 calls from pc 16'h0010,16'h0020,16'h0030,16'h0040,16'h0050, then 5 jr -> targets 16'h0052,16'h0042,16'h0032,16'h0022, then jr_target with ras_miss=1.
REQ-032 jalr (macro on): RAS top 16'h0032, jr+call at pc 16'h0060 -> target 16'h0032, top becomes 16'h0062, count unchanged.
